// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data memory between port A (CPU load/store stage)
//   and port B (debug/DMA loader). One request per port is accepted, a winner
//   is chosen (round-robin, or A-first when FIXED_PRIO=1) and exactly one DMEM
//   command is issued per transaction. Read data is returned with an rvalid
//   strobe aligned to DMEM's registered read output.
//
// Parameters
//   ADDR_W      DMEM word-address width
//   DATA_W      data width
//   FIXED_PRIO  0 = round-robin tie break, 1 = port A always wins ties
//
// Ports
//   DARB_clk, DARB_rst_n          clock, asynchronous active-low reset
//   {A,B}_req/_we/_addr/_wdata    per-port request, held until gnt is sampled
//   {A,B}_gnt                     one-cycle pulse while the command is on DMEM
//   {A,B}_rvalid, {A,B}_rdata     read return (rdata is DMEM_rdata directly)
//   DMEM_addr/_wdata/_write/_read command to DMEM, DMEM_rdata its read output
//   busy                          high while in CMD or RESP
module dmem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              DARB_clk,
  input  logic              DARB_rst_n,
  input  logic              A_req,
  input  logic              A_we,
  input  logic [ADDR_W-1:0] A_addr,
  input  logic [DATA_W-1:0] A_wdata,
  output logic              A_gnt,
  output logic              A_rvalid,
  output logic [DATA_W-1:0] A_rdata,
  input  logic              B_req,
  input  logic              B_we,
  input  logic [ADDR_W-1:0] B_addr,
  input  logic [DATA_W-1:0] B_wdata,
  output logic              B_gnt,
  output logic              B_rvalid,
  output logic [DATA_W-1:0] B_rdata,
  output logic [ADDR_W-1:0] DMEM_addr,
  output logic [DATA_W-1:0] DMEM_wdata,
  output logic              DMEM_write,
  output logic              DMEM_read,
  input  logic [DATA_W-1:0] DMEM_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;

  state_t state, state_d;

  logic win_b;   // latched winner: 1 = port B
  logic we_q;    // latched write flag of the transaction in flight
  logic last_b;  // last grant went to port B

  logic              arb;
  logic              pick_b;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              a_rvalid_d;
  logic              b_rvalid_d;

  assign A_rdata = DMEM_rdata;
  assign B_rdata = DMEM_rdata;

  always_comb begin
    state_d    = state;
    arb        = 1'b0;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    case (state)
      IDLE, RESP: begin
        arb     = A_req | B_req;
        state_d = arb ? CMD : IDLE;
      end
      CMD: begin
        state_d    = RESP;
        a_rvalid_d = ~we_q & ~win_b;
        b_rvalid_d = ~we_q &  win_b;
      end
      default: state_d = IDLE;
    endcase

    // B wins when alone, or on a tie in round-robin mode when A was served last.
    pick_b    = B_req & (~A_req | ((FIXED_PRIO == 0) & ~last_b));
    sel_we    = pick_b ? B_we    : A_we;
    sel_addr  = pick_b ? B_addr  : A_addr;
    sel_wdata = pick_b ? B_wdata : A_wdata;
  end

  // Every output is registered from its next-cycle value, so the command and
  // gnt appear in the cycle after the sampling edge. DMEM_addr/DMEM_wdata
  // double as the latched transaction fields and hold outside CMD.
  always_ff @(posedge DARB_clk or negedge DARB_rst_n) begin
    if (!DARB_rst_n) begin
      state      <= IDLE;
      win_b      <= 1'b0;
      we_q       <= 1'b0;
      last_b     <= 1'b1;
      A_gnt      <= 1'b0;
      B_gnt      <= 1'b0;
      A_rvalid   <= 1'b0;
      B_rvalid   <= 1'b0;
      DMEM_write <= 1'b0;
      DMEM_read  <= 1'b0;
      DMEM_addr  <= '0;
      DMEM_wdata <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      A_gnt      <= arb & ~pick_b;
      B_gnt      <= arb &  pick_b;
      DMEM_write <= arb &  sel_we;
      DMEM_read  <= arb & ~sel_we;
      A_rvalid   <= a_rvalid_d;
      B_rvalid   <= b_rvalid_d;
      busy       <= (state_d != IDLE);
      if (arb) begin
        win_b      <= pick_b;
        we_q       <= sel_we;
        last_b     <= pick_b;
        DMEM_addr  <= sel_addr;
        DMEM_wdata <= sel_wdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic preload = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // instance 0: round-robin
  logic        a_req, a_we, b_req, b_we;
  logic [7:0]  a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic        A_gnt, A_rvalid, B_gnt, B_rvalid, dw0, dr0, busy0;
  logic [31:0] A_rdata, B_rdata, dwd0, rd0;
  logic [7:0]  da0;

  // instance 1: fixed priority
  logic        a1_req, a1_we, b1_req, b1_we;
  logic [7:0]  a1_addr, b1_addr;
  logic [31:0] a1_wdata, b1_wdata;
  logic        A1_gnt, A1_rvalid, B1_gnt, B1_rvalid, dw1, dr1, busy1;
  logic [31:0] A1_rdata, B1_rdata, dwd1, rd1;
  logic [7:0]  da1;

  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];

  dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .FIXED_PRIO(0)) u0 (
    .DARB_clk(clk), .DARB_rst_n(rst_n),
    .A_req(a_req), .A_we(a_we), .A_addr(a_addr), .A_wdata(a_wdata),
    .A_gnt(A_gnt), .A_rvalid(A_rvalid), .A_rdata(A_rdata),
    .B_req(b_req), .B_we(b_we), .B_addr(b_addr), .B_wdata(b_wdata),
    .B_gnt(B_gnt), .B_rvalid(B_rvalid), .B_rdata(B_rdata),
    .DMEM_addr(da0), .DMEM_wdata(dwd0), .DMEM_write(dw0), .DMEM_read(dr0),
    .DMEM_rdata(rd0), .busy(busy0)
  );

  dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .FIXED_PRIO(1)) u1 (
    .DARB_clk(clk), .DARB_rst_n(rst_n),
    .A_req(a1_req), .A_we(a1_we), .A_addr(a1_addr), .A_wdata(a1_wdata),
    .A_gnt(A1_gnt), .A_rvalid(A1_rvalid), .A_rdata(A1_rdata),
    .B_req(b1_req), .B_we(b1_we), .B_addr(b1_addr), .B_wdata(b1_wdata),
    .B_gnt(B1_gnt), .B_rvalid(B1_rvalid), .B_rdata(B1_rdata),
    .DMEM_addr(da1), .DMEM_wdata(dwd1), .DMEM_write(dw1), .DMEM_read(dr1),
    .DMEM_rdata(rd1), .busy(busy1)
  );

  // DMEM models: synchronous write, registered read
  always @(posedge clk) begin
    if (preload) begin
      mem0[8'h10] <= 32'hDEADBEEF;
      mem0[8'h00] <= 32'h11;
      mem0[8'h01] <= 32'h22;
      mem1[8'h00] <= 32'h11;
    end
    if (dw0) mem0[da0] <= dwd0;
    if (dr0) rd0 <= mem0[da0];
    if (dw1) mem1[da1] <= dwd1;
    if (dr1) rd1 <= mem1[da1];
  end

  typedef struct {
    logic ar; logic aw; logic [7:0] aa; logic [31:0] ad;
    logic br; logic bw; logic [7:0] ba; logic [31:0] bd;
    logic eag; logic ebg; logic earv; logic ebrv; logic ew; logic er;
    logic [7:0] eaddr; logic [31:0] ewd; logic ebusy; logic [31:0] erd;
  } vec_t;

  function automatic vec_t mk(
    input logic ar, input logic aw, input logic [7:0] aa, input logic [31:0] ad,
    input logic br, input logic bw, input logic [7:0] ba, input logic [31:0] bd,
    input logic eag, input logic ebg, input logic earv, input logic ebrv,
    input logic ew, input logic er, input logic [7:0] eaddr, input logic [31:0] ewd,
    input logic ebusy, input logic [31:0] erd);
    vec_t v;
    v.ar = ar; v.aw = aw; v.aa = aa; v.ad = ad;
    v.br = br; v.bw = bw; v.ba = ba; v.bd = bd;
    v.eag = eag; v.ebg = ebg; v.earv = earv; v.ebrv = ebrv;
    v.ew = ew; v.er = er; v.eaddr = eaddr; v.ewd = ewd;
    v.ebusy = ebusy; v.erd = erd;
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_zero0(input string tag);
    chk1({tag, "_agnt"}, A_gnt, 1'b0);
    chk1({tag, "_bgnt"}, B_gnt, 1'b0);
    chk1({tag, "_arv"}, A_rvalid, 1'b0);
    chk1({tag, "_brv"}, B_rvalid, 1'b0);
    chk1({tag, "_wr"}, dw0, 1'b0);
    chk1({tag, "_rd"}, dr0, 1'b0);
    chk32({tag, "_addr"}, 32'(da0), 32'h0);
    chk32({tag, "_wdata"}, dwd0, 32'h0);
    chk1({tag, "_busy"}, busy0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vt [17];

  initial begin
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    a1_req = 0; a1_we = 0; a1_addr = '0; a1_wdata = '0;
    b1_req = 0; b1_we = 0; b1_addr = '0; b1_wdata = '0;

    //            A: req we addr  wdata        B: req we addr  wdata         gA gB rvA rvB wr rd addr  wdata        busy rdata
    vt[0]  = mk(1,0,8'h10,32'h0,        0,0,8'h00,32'h0,         1,0,0,0,0,1,8'h10,32'h0,        1,32'h0);
    vt[1]  = mk(1,0,8'h10,32'h0,        0,0,8'h00,32'h0,         0,0,1,0,0,0,8'h10,32'h0,        1,32'hDEADBEEF);
    vt[2]  = mk(0,0,8'h00,32'h0,        0,0,8'h00,32'h0,         0,0,0,0,0,0,8'h10,32'h0,        0,32'h0);
    vt[3]  = mk(0,0,8'h00,32'h0,        1,1,8'h3F,32'h12345678,  0,1,0,0,1,0,8'h3F,32'h12345678, 1,32'h0);
    vt[4]  = mk(0,0,8'h00,32'h0,        1,1,8'h3F,32'h12345678,  0,0,0,0,0,0,8'h3F,32'h12345678, 1,32'h0);
    vt[5]  = mk(0,0,8'h00,32'h0,        1,0,8'h3F,32'h0,         0,1,0,0,0,1,8'h3F,32'h0,        1,32'h0);
    vt[6]  = mk(0,0,8'h00,32'h0,        1,0,8'h3F,32'h0,         0,0,0,1,0,0,8'h3F,32'h0,        1,32'h12345678);
    vt[7]  = mk(0,0,8'h00,32'h0,        0,0,8'h00,32'h0,         0,0,0,0,0,0,8'h3F,32'h0,        0,32'h0);
    vt[8]  = mk(1,0,8'h00,32'h0,        1,0,8'h01,32'h0,         1,0,0,0,0,1,8'h00,32'h0,        1,32'h0);
    vt[9]  = mk(1,0,8'h00,32'h0,        1,0,8'h01,32'h0,         0,0,1,0,0,0,8'h00,32'h0,        1,32'h11);
    vt[10] = mk(1,0,8'h00,32'h0,        1,0,8'h01,32'h0,         0,1,0,0,0,1,8'h01,32'h0,        1,32'h0);
    vt[11] = mk(1,0,8'h00,32'h0,        1,0,8'h01,32'h0,         0,0,0,1,0,0,8'h01,32'h0,        1,32'h22);
    vt[12] = mk(1,0,8'h00,32'h0,        1,0,8'h01,32'h0,         1,0,0,0,0,1,8'h00,32'h0,        1,32'h0);
    vt[13] = mk(1,0,8'h00,32'h0,        1,0,8'h01,32'h0,         0,0,1,0,0,0,8'h00,32'h0,        1,32'h11);
    vt[14] = mk(1,0,8'h00,32'h0,        1,0,8'h01,32'h0,         0,1,0,0,0,1,8'h01,32'h0,        1,32'h0);
    vt[15] = mk(1,0,8'h00,32'h0,        1,0,8'h01,32'h0,         0,0,0,1,0,0,8'h01,32'h0,        1,32'h22);
    vt[16] = mk(0,0,8'h00,32'h0,        0,0,8'h00,32'h0,         0,0,0,0,0,0,8'h01,32'h0,        0,32'h0);

    // reset state
    #12;
    chk_zero0("reset");
    chk1("reset_u1_busy", busy1, 1'b0);
    chk1("reset_u1_agnt", A1_gnt, 1'b0);
    chk1("reset_u1_bgnt", B1_gnt, 1'b0);
    preload = 1'b0;
    #1 rst_n = 1'b1;

    // round-robin instance: directed vectors
    for (int i = 0; i < 17; i++) begin
      a_req = vt[i].ar; a_we = vt[i].aw; a_addr = vt[i].aa; a_wdata = vt[i].ad;
      b_req = vt[i].br; b_we = vt[i].bw; b_addr = vt[i].ba; b_wdata = vt[i].bd;
      tick();
      chk1($sformatf("v%0d_agnt", i), A_gnt, vt[i].eag);
      chk1($sformatf("v%0d_bgnt", i), B_gnt, vt[i].ebg);
      chk1($sformatf("v%0d_arv", i), A_rvalid, vt[i].earv);
      chk1($sformatf("v%0d_brv", i), B_rvalid, vt[i].ebrv);
      chk1($sformatf("v%0d_wr", i), dw0, vt[i].ew);
      chk1($sformatf("v%0d_rd", i), dr0, vt[i].er);
      chk32($sformatf("v%0d_addr", i), 32'(da0), 32'(vt[i].eaddr));
      chk32($sformatf("v%0d_wdata", i), dwd0, vt[i].ewd);
      chk1($sformatf("v%0d_busy", i), busy0, vt[i].ebusy);
      if (vt[i].earv) chk32($sformatf("v%0d_ardata", i), A_rdata, vt[i].erd);
      if (vt[i].ebrv) chk32($sformatf("v%0d_brdata", i), B_rdata, vt[i].erd);
    end
    chk32("mem_3f", mem0[8'h3F], 32'h12345678);

    // reset while an A read is in CMD
    a_req = 1; a_we = 0; a_addr = 8'h10; a_wdata = '0;
    tick();
    chk1("rstcmd_agnt", A_gnt, 1'b1);
    chk1("rstcmd_rd", dr0, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_zero0("rst_async");
    a_req = 0;
    tick();
    chk_zero0("rst_held");
    #2 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk1($sformatf("post_rst%0d_arv", c), A_rvalid, 1'b0);
      chk1($sformatf("post_rst%0d_busy", c), busy0, 1'b0);
    end
    // pointer was A-last before reset; reset restores B-last, so A takes the tie
    a_req = 1; a_we = 0; a_addr = 8'h00;
    b_req = 1; b_we = 0; b_addr = 8'h01;
    tick();
    chk1("post_rst_tie_agnt", A_gnt, 1'b1);
    chk1("post_rst_tie_bgnt", B_gnt, 1'b0);
    chk32("post_rst_tie_addr", 32'(da0), 32'h00);
    a_req = 0; b_req = 0;
    tick();
    chk1("post_rst_arv", A_rvalid, 1'b1);
    chk32("post_rst_ardata", A_rdata, 32'h11);

    // fixed-priority instance: A keeps re-requesting, B waits with a write
    a1_req = 1; a1_we = 0; a1_addr = 8'h00; a1_wdata = '0;
    b1_req = 1; b1_we = 1; b1_addr = 8'h20; b1_wdata = 32'hCAFEF00D;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk1($sformatf("fp%0d_agnt", s), A1_gnt, 1'b1);
      chk1($sformatf("fp%0d_bgnt", s), B1_gnt, 1'b0);
      chk1($sformatf("fp%0d_rd", s), dr1, 1'b1);
      tick();
      chk1($sformatf("fp%0d_arv", s), A1_rvalid, 1'b1);
      chk32($sformatf("fp%0d_ardata", s), A1_rdata, 32'h11);
      chk1($sformatf("fp%0d_busy", s), busy1, 1'b1);
    end
    a1_req = 0;
    tick();
    chk1("fp_b_bgnt", B1_gnt, 1'b1);
    chk1("fp_b_agnt", A1_gnt, 1'b0);
    chk1("fp_b_wr", dw1, 1'b1);
    chk1("fp_b_rd", dr1, 1'b0);
    chk32("fp_b_addr", 32'(da1), 32'h20);
    chk32("fp_b_wdata", dwd1, 32'hCAFEF00D);
    tick();
    b1_req = 0;
    chk1("fp_b_norv", B1_rvalid, 1'b0);
    chk1("fp_b_wr_off", dw1, 1'b0);
    chk1("fp_b_busy", busy1, 1'b1);
    tick();
    chk1("fp_idle_busy", busy1, 1'b0);
    chk32("fp_mem_20", mem1[8'h20], 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single-port data memory (DMEM). It shares DMEM between port A (CPU load/store stage) and port B (debug/DMA loader). It accepts one request per port, picks a winner (round-robin, or fixed priority for A), and drives exactly one DMEM command per transaction. It returns read data with a valid strobe timed to DMEM's registered read output.

## Interface
- ADDR_W, 8, DMEM word-address width
- DATA_W, 32, data width
- FIXED_PRIO, 0, 0 = round-robin; 1 = port A always wins ties

- DARB_clk  in  1  clock; all state changes on rising edge
- DARB_rst_n  in  1  asynchronous, active-low reset
- A_req  in  1  port A request; hold with fields stable until A_gnt is sampled high
- A_we  in  1  1 = write, 0 = read
- A_addr  in  ADDR_W  word address
- A_wdata  in  DATA_W  write data
- A_gnt  out  1  one-cycle pulse; command issued to DMEM this cycle
- A_rvalid  out  1  one-cycle pulse; A_rdata valid (reads only)
- A_rdata  out  DATA_W  read data, equal to DMEM_rdata
- B_req, B_we, B_addr, B_wdata, B_gnt, B_rvalid, B_rdata: as port A, for port B
- DMEM_addr  out  ADDR_W  to DMEM address
- DMEM_wdata  out  DATA_W  to DMEM data in
- DMEM_write  out  1  to DMEM write enable
- DMEM_read  out  1  to DMEM read enable
- DMEM_rdata  in  DATA_W  from DMEM registered data out
- busy  out  1  high in CMD or RESP

## Operation
- FSM states: IDLE, CMD, RESP. All outputs are registered except A_rdata/B_rdata, which are wires from DMEM_rdata.
- IDLE: if any req is high, latch winner, we, addr, wdata at the edge and go to CMD. Otherwise stay.
- Winner selection:
  - Single requester always wins.
  - Both requesting with FIXED_PRIO=1: A wins.
  - Both requesting with FIXED_PRIO=0: the port not granted last wins. The last-grant pointer updates on every grant.
- CMD (exactly 1 cycle):
  - winner's gnt = 1.
  - DMEM_addr/DMEM_wdata = latched values.
  - DMEM_write = latched we; DMEM_read = !latched we.
  - Next state is always RESP.
- RESP (1 cycle):
  - If the transaction was a read, winner's rvalid = 1.
  - Arbitrates exactly like IDLE: a pending req goes to CMD, otherwise go to IDLE.
- DMEM_write and DMEM_read are never both high; both are 0 outside CMD. DMEM_addr/DMEM_wdata hold their last values outside CMD.
- The loser's req stays pending and is served in the next arbitration slot. No request is dropped.
- Round-robin guarantees each waiting port a grant within 2 transactions.

## Timing
- Reset (async assert, sync-released by the system):
  - state = IDLE; all gnt, rvalid, DMEM_write, DMEM_read, busy = 0.
  - DMEM_addr = 0, DMEM_wdata = 0.
  - Pointer = "B last", so A wins the first tie.
- Request sampled at edge k → gnt and DMEM command high in cycle k..k+1.
- DMEM performs the write or registers the read at edge k+1.
- rvalid is high in cycle k+1..k+2, with rdata = DMEM_rdata = mem[addr].
- Read latency: 2 edges from the sampling edge.
- Peak throughput: 1 transaction per 2 cycles; back-to-back goes CMD→RESP→CMD.
- Requester sees gnt at edge k+1 and must drop or change req right after it. req seen at edge k+2 is treated as a new request.
- Reset mid-CMD or mid-RESP: the transaction is aborted immediately.
  - Read aborted in CMD: DMEM_read clears before the edge, so DMEM does not read.
  - rvalid is never issued after reset.
  - A write whose edge k+1 was already reached is complete.
- rdata outside an rvalid cycle is don't-care.

## Test plan
- Single read: preload mem[0x10]=0xDEADBEEF; A_req=1, A_we=0, A_addr=0x10 → A_gnt one cycle after the sampling edge, DMEM_read=1 in that cycle, A_rvalid next cycle with A_rdata=0xDEADBEEF; B_gnt/B_rvalid stay 0.
- Write then read: B writes 0x12345678 to 0x3F, then B reads 0x3F → DMEM_write=1 exactly one cycle with addr 0x3F; read returns 0x12345678 two edges after its sampling edge; no rvalid for the write.
- Simultaneous contention, FIXED_PRIO=0, both held for 4 transactions → grant order A,B,A,B; one gnt per 2 cycles; DMEM_write&DMEM_read never both 1.
- Same contention, FIXED_PRIO=1, A re-requests immediately after each grant → A granted every slot; B granted only after A_req drops; B's fields unchanged at its grant.
- Back-to-back: A read 0x00 then B read 0x01 with data 0x11/0x22 → CMD,RESP,CMD,RESP with no IDLE cycle; A_rvalid with 0x11, then B_rvalid with 0x22; busy continuously high.
- Reset in CMD of an A read → all outputs 0 asynchronously; no A_rvalid afterward; first post-reset tie goes to A.
